cr_kme_hmac_tag_collect: RTL and testbench
==========================================

CR_KME_HMAC_TAG_COLLECT -- requirements
Module: cr_kme_hmac_tag_collect

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of delivered-tag counter.
REQ-002 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: sha_tag_data  input  128  tag beat from HMAC-SHA256 engine.
REQ-005 SHALL have port: sha_tag_valid  input  1  beat valid.
REQ-006 SHALL have port: sha_tag_last  input  1  final beat of tag.
REQ-007 SHALL have port: sha_tag_stall  output  1  backpressure to engine; beat accepted iff valid && !stall.
REQ-008 SHALL have port: expected_tag  input  256  reference tag for compare feature.
REQ-009 SHALL have port: tag_data  output  256  assembled tag, first beat in [255:128].
REQ-010 SHALL have port: tag_valid  output  1  assembled tag available.
REQ-011 SHALL have port: tag_ack  input  1  consumer takes tag when tag_valid && tag_ack.
REQ-012 SHALL have port: tag_err  output  1  framing error on held tag (short or overlong).
REQ-013 SHALL have port: tag_match  output  1  held tag equals expected_tag (compare feature).
REQ-014 SHALL have port: tag_cnt  output  CNT_W  count of tags delivered to consumer.

Function
REQ-015 SHALL implement FSM states BEAT0, BEAT1, DRAIN, FULL.
REQ-016 BEAT0: accepted beat stored to tag_data[255:128]; last=0 -> BEAT1; last=1 -> tag_data[127:0]=0, err set, -> FULL.
REQ-017 BEAT1: accepted beat stored to tag_data[127:0]; last=1 -> FULL; last=0 -> err set, -> DRAIN.
REQ-018 DRAIN: accepted beats discarded, tag_data unchanged; last=1 -> FULL.
REQ-019 sha_tag_stall SHALL be 1 only in FULL, 0 in BEAT0/BEAT1/DRAIN.
REQ-020 tag_valid SHALL be 1 exactly in FULL; tag_data, tag_err, tag_match stable while tag_valid=1.
REQ-021 FULL with tag_ack=1 -> BEAT0 next cycle, err cleared, tag_cnt+1 (wraps from all-ones to 0).
REQ-022 Beat arriving in same cycle as tag_ack SHALL NOT be accepted (stall still 1); one-cycle bubble per tag.
REQ-023 Latency: tag_valid SHALL assert the cycle after the last beat is accepted.
REQ-024 tag_ack while tag_valid=0 SHALL be ignored.
REQ-025 Valid=0 cycles in any state SHALL hold state and data.

Reset
REQ-026 On clk edge with rst_n=0: state BEAT0, tag_data=0, tag_err=0, tag_match=0, tag_cnt=0, tag_valid=0, sha_tag_stall=0.
REQ-027 Reset mid-tag (BEAT1/DRAIN/FULL) SHALL discard the partial or held tag with no tag_cnt increment.

Configuration
REQ-028 Macro CR_KME_TAG_CMP_EN SHALL gate the compare feature.
REQ-029 Defined: tag_match registered on entry to FULL as (assembled tag == expected_tag) && !err, sampled at the cycle of the final accepted beat.
REQ-030 Undefined: tag_match tied 0, expected_tag unused, no comparator logic; all other behaviour identical.

Verification
REQ-031 Two beats A=0x11..11, B=0x22..22, last on B, ack 2 cycles later -> tag_data={A,B}, tag_err=0, tag_valid 2 cycles, tag_cnt 0->1.
REQ-032 Single beat C with last=1 -> tag_data={C,128'h0}, tag_err=1, tag_match=0.
REQ-033 Four beats, last on 4th -> tag_data=first two beats, tag_err=1, beats 3-4 accepted without stall.
REQ-034 Tag held, tag_ack low 10 cycles with valid beat pending -> stall=1 throughout, beat accepted the cycle after ack.
REQ-035 With CR_KME_TAG_CMP_EN, expected_tag={A,B} then {A,~B} -> tag_match 1 then 0; without macro -> 0 both.
REQ-036 rst_n=0 in BEAT1, then 2^CNT_W ack'd tags -> no partial tag emitted, tag_cnt wraps to 0.

Source files
------------

// File: rtl/cr_kme_hmac_tag_collect.sv
// Builds one 256-bit HMAC tag from two 128-bit SHA engine beats and holds it until the consumer acks.
// The optional compare against expected_tag is enabled by defining CR_KME_TAG_CMP_EN.
module cr_kme_hmac_tag_collect #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [127:0]     sha_tag_data,
   input  logic             sha_tag_valid,
   input  logic             sha_tag_last,
   output logic             sha_tag_stall,
   input  logic [255:0]     expected_tag,
   output logic [255:0]     tag_data,
   output logic             tag_valid,
   input  logic             tag_ack,
   output logic             tag_err,
   output logic             tag_match,
   output logic [CNT_W-1:0] tag_cnt
);

   typedef enum logic [1:0] {
      BEAT0 = 2'd0,
      BEAT1 = 2'd1,
      DRAIN = 2'd2,
      FULL  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic accept;
   logic store_hi;
   logic store_lo;
   logic clear_lo;
   logic err_set;
   logic release_tag;
   logic full_entry;

   // The engine sees stall for the whole time a tag is held, including the ack
   // cycle, so each delivered tag costs one idle input cycle.
   assign sha_tag_stall = (state == FULL);
   assign tag_valid     = (state == FULL);
   assign accept        = sha_tag_valid && (state != FULL);
   assign full_entry    = (state_nxt == FULL) && (state != FULL);

   always_comb begin
      state_nxt   = state;
      store_hi    = 1'b0;
      store_lo    = 1'b0;
      clear_lo    = 1'b0;
      err_set     = 1'b0;
      release_tag = 1'b0;
      case (state)
         BEAT0: begin
            if (accept) begin
               store_hi = 1'b1;
               if (sha_tag_last) begin
                  clear_lo  = 1'b1;
                  err_set   = 1'b1;
                  state_nxt = FULL;
               end else begin
                  state_nxt = BEAT1;
               end
            end
         end
         BEAT1: begin
            if (accept) begin
               store_lo = 1'b1;
               if (sha_tag_last) begin
                  state_nxt = FULL;
               end else begin
                  err_set   = 1'b1;
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (accept && sha_tag_last) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (tag_ack) begin
               release_tag = 1'b1;
               state_nxt   = BEAT0;
            end
         end
         default: begin
            state_nxt = BEAT0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= BEAT0;
         tag_data <= '0;
         tag_err  <= 1'b0;
         tag_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (store_hi) begin
            tag_data[255:128] <= sha_tag_data;
         end
         if (store_lo) begin
            tag_data[127:0] <= sha_tag_data;
         end
         if (clear_lo) begin
            tag_data[127:0] <= '0;
         end
         if (err_set) begin
            tag_err <= 1'b1;
         end else if (release_tag) begin
            tag_err <= 1'b0;
         end
         if (release_tag) begin
            tag_cnt <= tag_cnt + CNT_W'(1);
         end
      end
   end

`ifdef CR_KME_TAG_CMP_EN
   logic cmp_hit;

   // Only a clean two-beat tag closing from BEAT1 can match; every other way
   // into FULL carries a framing error and therefore reports no match.
   assign cmp_hit = (state == BEAT1) && !tag_err &&
                    ({tag_data[255:128], sha_tag_data} == expected_tag);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_match <= 1'b0;
      end else if (full_entry) begin
         tag_match <= cmp_hit;
      end else if (release_tag) begin
         tag_match <= 1'b0;
      end
   end
`else
   logic unused_expected_tag;
   logic unused_full_entry;

   assign unused_expected_tag = ^expected_tag;
   assign unused_full_entry   = full_entry;
   assign tag_match           = 1'b0;
`endif

endmodule

// File: tb/tb_cr_kme_hmac_tag_collect.sv
// Directed bench for cr_kme_hmac_tag_collect: stimulus pushes expected tags, a monitor pops on each handshake.
// Expected tag_match follows CR_KME_TAG_CMP_EN.
module tb_cr_kme_hmac_tag_collect;

   localparam int CNT_W = 4;

`ifdef CR_KME_TAG_CMP_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [127:0]     sha_tag_data;
   logic             sha_tag_valid;
   logic             sha_tag_last;
   logic             sha_tag_stall;
   logic [255:0]     expected_tag;
   logic [255:0]     tag_data;
   logic             tag_valid;
   logic             tag_ack;
   logic             tag_err;
   logic             tag_match;
   logic [CNT_W-1:0] tag_cnt;

   typedef struct {
      logic [255:0]     data;
      logic             err;
      logic             match;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   localparam logic [127:0] A = {16{8'h11}};
   localparam logic [127:0] B = {16{8'h22}};
   localparam logic [127:0] C = {16{8'h33}};
   localparam logic [127:0] D = {16{8'h44}};
   localparam logic [127:0] E = {16{8'h55}};
   localparam logic [127:0] F = {16{8'h66}};
   localparam logic [127:0] G = {16{8'h77}};
   localparam logic [127:0] H = {16{8'h88}};
   localparam logic [127:0] I = {16{8'h99}};
   localparam logic [127:0] J = {16{8'haa}};
   localparam logic [127:0] K = {16{8'hbb}};
   localparam logic [127:0] L = {16{8'hcc}};

   cr_kme_hmac_tag_collect #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sha_tag_data (sha_tag_data),
      .sha_tag_valid(sha_tag_valid),
      .sha_tag_last (sha_tag_last),
      .sha_tag_stall(sha_tag_stall),
      .expected_tag (expected_tag),
      .tag_data     (tag_data),
      .tag_valid    (tag_valid),
      .tag_ack      (tag_ack),
      .tag_err      (tag_err),
      .tag_match    (tag_match),
      .tag_cnt      (tag_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] want);
      n_checks++;
      if (actual !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, want);
      end
   endtask

   // Holds a beat until the DUT accepts it; returns the number of stalled cycles.
   task automatic apply_stimulus(input logic [127:0] data, input logic last, output int waits);
      sha_tag_data  = data;
      sha_tag_last  = last;
      sha_tag_valid = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (!sha_tag_stall) break;
         waits++;
         if (waits > 50) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL beat_accept_timeout: got stall=1, want stall=0 within 50 cycles");
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      sha_tag_valid = 1'b0;
      sha_tag_last  = 1'b0;
   endtask

   task automatic push_exp(input logic [255:0] data, input logic err, input logic match);
      exp_t e;
      e.data  = data;
      e.err   = err;
      e.match = match;
      e.cnt   = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic ack_tag();
      int n;
      n = 0;
      while (!tag_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!tag_valid) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL tag_valid_timeout: got tag_valid=0, want 1 within 50 cycles");
      end
      tag_ack = 1'b1;
      @(posedge clk);
      #1;
      tag_ack = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      check_output("tag_cnt_after_ack", 256'(tag_cnt), 256'(exp_cnt));
      check_output("tag_valid_after_ack", 256'(tag_valid), 256'(0));
   endtask

   // Scoreboard monitor: compare the held tag on every consumer handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && tag_valid === 1'b1 && tag_ack === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_tag: got tag %h, want no tag", tag_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_output("sb_tag_data", tag_data, e.data);
            check_output("sb_tag_err", 256'(tag_err), 256'(e.err));
            check_output("sb_tag_match", 256'(tag_match), 256'(e.match));
            check_output("sb_tag_cnt", 256'(tag_cnt), 256'(e.cnt));
         end
      end
   end

   initial begin
      int w;
      rst_n         = 1'b0;
      sha_tag_data  = '0;
      sha_tag_valid = 1'b0;
      sha_tag_last  = 1'b0;
      expected_tag  = '0;
      tag_ack       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_tag_valid", 256'(tag_valid), 256'(0));
      check_output("rst_stall", 256'(sha_tag_stall), 256'(0));
      check_output("rst_tag_data", tag_data, 256'(0));
      check_output("rst_tag_err", 256'(tag_err), 256'(0));
      check_output("rst_tag_match", 256'(tag_match), 256'(0));
      check_output("rst_tag_cnt", 256'(tag_cnt), 256'(0));
      rst_n = 1'b1;

      // Ack with nothing held is ignored.
      tag_ack = 1'b1;
      @(posedge clk);
      #1;
      tag_ack = 1'b0;
      check_output("idle_ack_cnt", 256'(tag_cnt), 256'(0));

      // Clean two-beat tag, matching expected_tag, acked two cycles later.
      expected_tag = {A, B};
      apply_stimulus(A, 1'b0, w);
      check_output("beat1_no_valid", 256'(tag_valid), 256'(0));
      apply_stimulus(B, 1'b1, w);
      push_exp({A, B}, 1'b0, CMP);
      check_output("latency_valid", 256'(tag_valid), 256'(1));
      @(posedge clk);
      #1;
      check_output("valid_held", 256'(tag_valid), 256'(1));
      check_output("stall_held", 256'(sha_tag_stall), 256'(1));
      ack_tag();

      // Same beats, expected_tag with inverted low half.
      expected_tag = {A, ~B};
      apply_stimulus(A, 1'b0, w);
      apply_stimulus(B, 1'b1, w);
      push_exp({A, B}, 1'b0, 1'b0);
      ack_tag();

      // Short tag.
      expected_tag = {C, 128'h0};
      apply_stimulus(C, 1'b1, w);
      push_exp({C, 128'h0}, 1'b1, 1'b0);
      check_output("short_valid", 256'(tag_valid), 256'(1));
      ack_tag();

      // Overlong tag: beats 3 and 4 are drained without stall.
      expected_tag = {D, E};
      apply_stimulus(D, 1'b0, w);
      apply_stimulus(E, 1'b0, w);
      check_output("drain_no_valid", 256'(tag_valid), 256'(0));
      apply_stimulus(F, 1'b0, w);
      check_output("drain_beat3_waits", 256'(w), 256'(0));
      apply_stimulus(G, 1'b1, w);
      check_output("drain_beat4_waits", 256'(w), 256'(0));
      push_exp({D, E}, 1'b1, 1'b0);
      ack_tag();

      // Held tag with a pending beat: stall throughout, beat taken after the bubble.
      expected_tag = '0;
      apply_stimulus(H, 1'b0, w);
      apply_stimulus(I, 1'b1, w);
      push_exp({H, I}, 1'b0, 1'b0);
      sha_tag_data  = J;
      sha_tag_last  = 1'b0;
      sha_tag_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_output("hold_stall", 256'(sha_tag_stall), 256'(1));
         @(posedge clk);
         #1;
      end
      tag_ack = 1'b1;
      @(negedge clk);
      check_output("ack_cycle_stall", 256'(sha_tag_stall), 256'(1));
      @(posedge clk);
      #1;
      tag_ack = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      check_output("bubble_no_stall", 256'(sha_tag_stall), 256'(0));
      expected_tag = {J, K};
      @(posedge clk);
      #1;
      apply_stimulus(K, 1'b1, w);
      check_output("pending_second_waits", 256'(w), 256'(0));
      push_exp({J, K}, 1'b0, CMP);
      ack_tag();

      // Reset while in BEAT1 drops the partial tag and the count.
      apply_stimulus(L, 1'b0, w);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_cnt = '0;
      check_output("midrst_valid", 256'(tag_valid), 256'(0));
      check_output("midrst_cnt", 256'(tag_cnt), 256'(0));
      check_output("midrst_data", tag_data, 256'(0));

      // A full counter's worth of tags wraps tag_cnt back to zero.
      expected_tag = '0;
      for (int t = 0; t < (1 << CNT_W); t++) begin
         apply_stimulus(128'(t + 1), 1'b0, w);
         apply_stimulus(~128'(t), 1'b1, w);
         push_exp({128'(t + 1), ~128'(t)}, 1'b0, 1'b0);
         ack_tag();
      end
      check_output("wrap_cnt", 256'(tag_cnt), 256'(0));

      repeat (2) @(posedge clk);
      check_output("sb_drained", 256'(sb.size()), 256'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
